bp_ghr_tracker: RTL

BP_GHR_TRACKER -- requirements
Module: bp_ghr_tracker

---
 rtl/ariane_pkg.sv | 34 +++
 rtl/bp_ghr_fifo.sv | 76 +++++++
 rtl/bp_ghr_tracker.sv | 107 ++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// ariane_pkg: shared frontend types for the branch-prediction path.
//   ghr_t          - global history vector at the default history length
//   bht_update_t   - branch history table update bundle
//   ghr_predict_t  - frontend prediction handshake fields
//   ghr_resolve_t  - execute-stage resolution fields
//   sat_inc16      - saturating 16-bit increment used by statistics counters
package ariane_pkg;

  localparam int unsigned GHR_LEN = 10;

  typedef logic [GHR_LEN-1:0] ghr_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic        taken;
  } bht_update_t;

  typedef struct packed {
    logic valid;
    logic taken;
  } ghr_predict_t;

  typedef struct packed {
    logic valid;
    logic taken;
    logic mispredict;
  } ghr_resolve_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bp_ghr_fifo.sv
// bp_ghr_fifo: circular buffer of predicted directions for in-flight branches.
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   push_i, data_i - append one entry at the tail
//   pop_i          - drop the head entry
//   clear_i        - squash all entries (wins over push/pop)
//   data_o         - head entry
//   full_o/empty_o - occupancy flags
//   count_o        - number of entries held
//   tail_o         - current tail pointer (slot the next push uses)
module bp_ghr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic             data_i,
  output logic             data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o,
  output logic [PTR_W-1:0] tail_o
);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      // Collapse onto the tail so tag numbering continues after a squash.
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + 1'b1;
      if (pop_i)  head_d = head_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[tail_q] <= data_i;
  end

  assign data_o  = mem_q[head_q];
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign tail_o  = tail_q;

endmodule

// File: rtl/bp_ghr_tracker.sv
// bp_ghr_tracker: speculative / committed global history tracker for a
// perceptron branch predictor.
// Ports:
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   flush_i                      - frontend flush, restores spec history
//   predict_valid_i/taken_i      - predicted conditional branch from frontend
//   predict_ready_o, predict_tag_o - accept handshake and assigned tag
//   resolve_valid_i/taken_i/mispredict_i - resolution of the oldest branch
//   spec_ghr_o, commit_ghr_o     - speculative and committed history
//   count_o                      - in-flight branch count
//   mispredict_cnt_o             - mispredict statistics
// Build option: define BP_GHR_STATS_EN to enable the saturating mispredict
// counter; otherwise mispredict_cnt_o is tied to zero.
module bp_ghr_tracker
  import ariane_pkg::*;
#(
  parameter int unsigned GHR_LENGTH = 10,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     predict_valid_i,
  input  logic                     predict_taken_i,
  output logic                     predict_ready_o,
  output logic [$clog2(DEPTH)-1:0] predict_tag_o,
  input  logic                     resolve_valid_i,
  input  logic                     resolve_taken_i,
  input  logic                     resolve_mispredict_i,
  output logic [GHR_LENGTH-1:0]    spec_ghr_o,
  output logic [GHR_LENGTH-1:0]    commit_ghr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              mispredict_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  ghr_predict_t pred;
  ghr_resolve_t res;
  assign pred = '{valid: predict_valid_i, taken: predict_taken_i};
  assign res  = '{valid: resolve_valid_i, taken: resolve_taken_i,
                  mispredict: resolve_mispredict_i};

  logic [GHR_LENGTH-1:0] spec_q, spec_d;
  logic [GHR_LENGTH-1:0] commit_q, commit_d;
  logic                  full, empty;
  logic                  accept, res_ok, mispredict, squash;
  logic                  head_taken_unused;

  assign accept     = pred.valid && !full;
  assign res_ok     = res.valid && !empty;
  assign mispredict = res_ok && res.mispredict;
  assign squash     = mispredict || flush_i;

  always_comb begin
    commit_d = commit_q;
    if (res_ok) commit_d = {commit_q[GHR_LENGTH-2:0], res.taken};
    spec_d = spec_q;
    // A squash restores from the committed history including this cycle's
    // resolution; any same-cycle accept is lost with the squash.
    if (squash)      spec_d = commit_d;
    else if (accept) spec_d = {spec_q[GHR_LENGTH-2:0], pred.taken};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spec_q   <= '0;
      commit_q <= '0;
    end else begin
      spec_q   <= spec_d;
      commit_q <= commit_d;
    end
  end

  bp_ghr_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept && !squash),
    .pop_i   (res_ok && !squash),
    .clear_i (squash),
    .data_i  (pred.taken),
    .data_o  (head_taken_unused),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o),
    .tail_o  (predict_tag_o)
  );

  assign predict_ready_o = !full;
  assign spec_ghr_o      = spec_q;
  assign commit_ghr_o    = commit_q;

`ifdef BP_GHR_STATS_EN
  logic [15:0] mis_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)           mis_cnt_q <= '0;
    else if (mispredict) mis_cnt_q <= sat_inc16(mis_cnt_q);
  end
  assign mispredict_cnt_o = mis_cnt_q;
`else
  assign mispredict_cnt_o = '0;
`endif

endmodule
